// File: rtl/input_cond_pkg.sv
// Shared types and defaults for the input conditioner front end.
package input_cond_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } cond_state_t;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/sync_chain.sv
// Plain flop chain that brings an asynchronous level into the clk domain.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (SYNC_STAGES < 2) begin : g_stage_check
        $error("sync_chain: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronise, debounce and glitch-count an external level before edge detection.
// state       | meaning
// STABLE_LOW  | sig_clean low, waiting for a high sample
// WAIT_HIGH   | qualifying a rise, cnt = consecutive high samples
// STABLE_HIGH | sig_clean high, waiting for a low sample
// WAIT_LOW    | qualifying a fall, cnt = consecutive low samples
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sig_raw,
    output logic                sig_clean,
    output logic                settling,
    output logic                glitch_pulse,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    if (DEBOUNCE_CYCLES < 2) begin : g_debounce_check
        $error("input_conditioner: DEBOUNCE_CYCLES must be at least 2");
    end

    logic             sync_q;
    cond_state_t      state;
    logic [CNT_W-1:0] cnt;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_chain (
        .clk(clk),
        .rst(rst),
        .d  (sig_raw),
        .q  (sync_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= STABLE_LOW;
            cnt          <= '0;
            sig_clean    <= 1'b0;
            glitch_pulse <= 1'b0;
            glitch_cnt   <= '0;
        end else begin
            glitch_pulse <= 1'b0;
            case (state)
                STABLE_LOW: begin
                    if (sync_q) begin
                        state <= WAIT_HIGH;
                        cnt   <= CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync_q) begin
                        state        <= STABLE_LOW;
                        cnt          <= '0;
                        glitch_pulse <= 1'b1;
                        if (glitch_cnt != GLITCH_MAX) glitch_cnt <= glitch_cnt + GLITCH_W'(1);
                    end else if (cnt == CNT_LAST) begin
                        state     <= STABLE_HIGH;
                        sig_clean <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync_q) begin
                        state <= WAIT_LOW;
                        cnt   <= CNT_ONE;
                    end
                end
                WAIT_LOW: begin
                    // A high sample while qualifying a fall is the mirror-image glitch.
                    if (sync_q) begin
                        state        <= STABLE_HIGH;
                        cnt          <= '0;
                        glitch_pulse <= 1'b1;
                        if (glitch_cnt != GLITCH_MAX) glitch_cnt <= glitch_cnt + GLITCH_W'(1);
                    end else if (cnt == CNT_LAST) begin
                        state     <= STABLE_LOW;
                        sig_clean <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign settling = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: defaults, narrow glitch counter and minimum debounce.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       raw_a, raw_b, raw_c;
    logic       clean_a, clean_b, clean_c;
    logic       settling_a, settling_b, settling_c;
    logic       gp_a, gp_b, gp_c;
    logic [7:0] gcnt_a, gcnt_c;
    logic [1:0] gcnt_b;

    always #5 clk = ~clk;

    input_conditioner dut_a (
        .clk(clk), .rst(rst), .sig_raw(raw_a), .sig_clean(clean_a),
        .settling(settling_a), .glitch_pulse(gp_a), .glitch_cnt(gcnt_a)
    );

    input_conditioner #(.GLITCH_W(2)) dut_b (
        .clk(clk), .rst(rst), .sig_raw(raw_b), .sig_clean(clean_b),
        .settling(settling_b), .glitch_pulse(gp_b), .glitch_cnt(gcnt_b)
    );

    input_conditioner #(.DEBOUNCE_CYCLES(2)) dut_c (
        .clk(clk), .rst(rst), .sig_raw(raw_c), .sig_clean(clean_c),
        .settling(settling_c), .glitch_pulse(gp_c), .glitch_cnt(gcnt_c)
    );

    typedef struct {
        int   sel;
        logic raw;
        logic clean;
        logic settling;
        logic gp;
        int   gcnt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input int sel, input logic raw, input logic clean,
                                input logic settling, input logic gp, input int gcnt);
        vec_t v;
        v.sel = sel; v.raw = raw; v.clean = clean;
        v.settling = settling; v.gp = gp; v.gcnt = gcnt;
        vecs.push_back(v);
    endfunction

    // Each vector drives raw before an edge and is scored just after that edge.
    task automatic run_vecs(input string tag);
        vec_t        e;
        logic        a_clean, a_settling, a_gp;
        logic [31:0] a_gcnt;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            case (vecs[i].sel)
                0:       raw_a = vecs[i].raw;
                1:       raw_b = vecs[i].raw;
                default: raw_c = vecs[i].raw;
            endcase
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            case (e.sel)
                0: begin
                    a_clean = clean_a; a_settling = settling_a; a_gp = gp_a; a_gcnt = 32'(gcnt_a);
                end
                1: begin
                    a_clean = clean_b; a_settling = settling_b; a_gp = gp_b; a_gcnt = 32'(gcnt_b);
                end
                default: begin
                    a_clean = clean_c; a_settling = settling_c; a_gp = gp_c; a_gcnt = 32'(gcnt_c);
                end
            endcase
            chk($sformatf("%s[%0d].sig_clean", tag, i), 32'(a_clean), 32'(e.clean));
            chk($sformatf("%s[%0d].settling", tag, i), 32'(a_settling), 32'(e.settling));
            chk($sformatf("%s[%0d].glitch_pulse", tag, i), 32'(a_gp), 32'(e.gp));
            chk($sformatf("%s[%0d].glitch_cnt", tag, i), a_gcnt, 32'(e.gcnt));
        end
        vecs.delete();
    endtask

    initial begin
        rst = 1'b1; raw_a = 1'b0; raw_b = 1'b0; raw_c = 1'b0;
        #12;
        chk("reset.clean_a", 32'(clean_a), 0);
        chk("reset.settling_a", 32'(settling_a), 0);
        chk("reset.glitch_pulse_a", 32'(gp_a), 0);
        chk("reset.glitch_cnt_a", 32'(gcnt_a), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int e = 1; e <= 20; e++) add(0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_vecs("idle");

        for (int e = 1; e <= 10; e++) add(0, 1'b1, e >= 6, (e >= 3 && e <= 5), 1'b0, 0);
        run_vecs("rise");

        for (int e = 1; e <= 10; e++) add(0, 1'b0, e < 6, (e >= 3 && e <= 5), 1'b0, 0);
        run_vecs("fall");

        // Two rejected high bursts, then a stable rise qualified six edges later.
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 1);
        add(0, 1, 0, 1, 0, 1);
        add(0, 1, 0, 0, 1, 2);
        add(0, 1, 0, 1, 0, 2);
        add(0, 1, 0, 1, 0, 2);
        add(0, 1, 0, 1, 0, 2);
        for (int e = 12; e <= 16; e++) add(0, 1, 1, 0, 0, 2);
        run_vecs("bounce");

        // Three-sample glitches against a 2-bit counter: 1,2,3,3,3.
        for (int k = 1; k <= 5; k++) begin
            for (int e = 1; e <= 8; e++)
                add(1, e <= 3, 1'b0, (e >= 3 && e <= 5), e == 6,
                    (e >= 6) ? ((k < 3) ? k : 3) : ((k - 1 < 3) ? k - 1 : 3));
        end
        run_vecs("saturate");

        for (int e = 1; e <= 6; e++) add(2, e == 1, 1'b0, e == 3, e == 4, (e >= 4) ? 1 : 0);
        run_vecs("deb2_short");

        for (int e = 1; e <= 10; e++)
            add(2, e <= 2, (e == 4 || e == 5), (e == 3 || e == 5), 1'b0, 1);
        run_vecs("deb2_pass");

        // Park dut_a low and dut_c high, then start a rise on dut_a and reset it at cnt=2.
        repeat (10) begin
            @(negedge clk);
            raw_a = 1'b0;
            raw_c = 1'b1;
        end
        @(negedge clk);
        raw_a = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midwait.settling_a", 32'(settling_a), 1);
        chk("midwait.clean_c", 32'(clean_c), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("async.clean_a", 32'(clean_a), 0);
        chk("async.settling_a", 32'(settling_a), 0);
        chk("async.glitch_pulse_a", 32'(gp_a), 0);
        chk("async.glitch_cnt_a", 32'(gcnt_a), 0);
        chk("async.glitch_cnt_b", 32'(gcnt_b), 0);
        chk("async.clean_c", 32'(clean_c), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("restart.edge5.clean_a", 32'(clean_a), 0);
        @(posedge clk);
        #1;
        chk("restart.edge6.clean_a", 32'(clean_a), 1);
        chk("restart.glitch_cnt_a", 32'(gcnt_a), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
